cero: RTL and testbench
=======================

CERO -- requirements
Module: cero

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 2..64.
REQ-002 The block SHALL have derived constant CW = clog2(WIDTH+1), default 6, giving the count width.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all registers update on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: one clock; reset is asynchronous and active-high.
REQ-005 Port en, input, 1 bit, SHALL be the capture enable for the registered status outputs.
REQ-006 Port a, input, WIDTH bits, SHALL be the operand under test.
REQ-007 Port Y, output, 1 bit, SHALL be the combinational zero flag.
REQ-008 Port zero_q, output, 1 bit, SHALL be the registered zero flag.
REQ-009 Port ones_q, output, 1 bit, SHALL be the registered all-ones flag.
REQ-010 Port lzc_q, output, CW bits, SHALL be the registered leading-zero count.
REQ-011 Port zcnt_q, output, 16 bits, SHALL be the registered count of captured zero operands.

Function
REQ-012 Y SHALL be 1 exactly when every bit of a is 0, else 0, with zero clock latency.
REQ-013 Y SHALL not depend on clk, rst or en, and SHALL remain valid during reset.
REQ-014 On a rising clk edge with en=1 and rst=0, zero_q SHALL load (a == 0).
REQ-015 Under the same condition, ones_q SHALL load (a == all ones).
REQ-016 Under the same condition, lzc_q SHALL load the number of consecutive 0 bits counted from bit WIDTH-1 downward.
REQ-017 lzc_q SHALL equal WIDTH when a = 0 and 0 when a[WIDTH-1] = 1.
REQ-018 Under the same capture condition, zcnt_q SHALL increment by 1 when a = 0.
REQ-019 zcnt_q SHALL saturate at 16'hFFFF and never wrap.
REQ-020 With en=0, all registered outputs SHALL hold their values.
REQ-021 The registered outputs SHALL have exactly one cycle of latency from a to output.
REQ-022 For WIDTH=1 treatment is out of scope; WIDTH outside 2..64 SHALL be rejected by an elaboration-time check.

Reset
REQ-023 While rst=1, zero_q=0, ones_q=0, lzc_q=0 and zcnt_q=0, applied immediately without waiting for clk.
REQ-024 The first capture after rst deasserts SHALL occur on the first rising edge with en=1.
REQ-025 Asserting rst mid-stream SHALL clear zcnt_q; the saturated state is not retained.

Structure
REQ-026 A shared package SHALL hold the default WIDTH, the CW derivation and the zcnt_q saturation constant.
REQ-027 The leading-zero count SHALL be a combinational sub-module cero_lzc (ports: a, count), built as a tree or priority scan.
REQ-028 The zero flag SHALL be a WIDTH-input NOR reduction and SHALL be shared between Y and zero_q.

Verification
REQ-029 Scenario: en=1, alternate a = 32'h0 / 32'hFFFFFFFF every 10 time units for 8 steps -> Y = 1,0,1,0,1,0,1,0 immediately; zero_q and ones_q follow one clock later; final zcnt_q=4.
REQ-030 Scenario: a = 32'h00010000 captured -> Y=0, zero_q=0, ones_q=0, lzc_q=15.
REQ-031 Scenario: a = 32'h80000000 -> lzc_q=0; a = 32'h00000001 -> lzc_q=31; a = 0 -> lzc_q=32.
REQ-032 Scenario: en=0 with a changing -> Y tracks a; registered outputs frozen.
REQ-033 Scenario: a = 0, en=1 for 65540 cycles -> zcnt_q stops at 16'hFFFF.
REQ-034 Scenario: assert rst asynchronously between edges with zcnt_q=7 -> all registered outputs are 0 at once; Y still equals (a == 0).

Source files
------------

// File: rtl/cero_pkg.sv
// -----------------------------------------------------------------------------
// cero_pkg
// Shared constants for the cero zero-detect / leading-zero-count block.
//   WIDTH_DEFAULT : default operand width
//   WIDTH_MIN/MAX : legal operand width range
//   ZCNT_W        : width of the zero-operand event counter
//   ZCNT_MAX      : saturation value of the zero-operand event counter
//   cw_of()       : count width needed to hold the values 0..WIDTH
// -----------------------------------------------------------------------------
package cero_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 64;

    localparam int              ZCNT_W   = 16;
    localparam logic [15:0]     ZCNT_MAX = 16'hFFFF;

    // The leading-zero count ranges over 0..WIDTH inclusive, so it needs
    // enough bits to represent WIDTH itself (an all-zero operand).
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : cero_pkg

// File: rtl/cero_lzc.sv
// -----------------------------------------------------------------------------
// cero_lzc
// Combinational leading-zero counter: counts consecutive 0 bits of a, starting
// at bit WIDTH-1 and moving toward bit 0.
//   a     : in,  WIDTH bits - operand
//   count : out, CW bits    - leading-zero count (WIDTH when a is all zero)
// -----------------------------------------------------------------------------
module cero_lzc
    import cero_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int CW   = cw_of(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    output logic [CW-1:0]    count
);

    logic           found_s;
    logic [CW-1:0]  count_s;

    // Priority scan from the MSB: the first 1 found fixes the count; an
    // operand with no 1 bits leaves the all-zero value WIDTH in place.
    always_comb begin
        found_s = 1'b0;
        count_s = CW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found_s && a[i]) begin
                found_s = 1'b1;
                count_s = CW'(WIDTH - 1 - i);
            end else begin
                found_s = found_s;
                count_s = count_s;
            end
        end
    end

    assign count = count_s;

endmodule : cero_lzc

// File: rtl/cero.sv
// -----------------------------------------------------------------------------
// cero
// Operand status block: combinational zero flag plus registered zero flag,
// all-ones flag, leading-zero count and a saturating count of captured zero
// operands.
//   clk    : in,  1 bit     - clock, rising edge
//   rst    : in,  1 bit     - asynchronous active-high reset
//   en     : in,  1 bit     - capture enable for the registered outputs
//   a      : in,  WIDTH     - operand under test
//   Y      : out, 1 bit     - combinational zero flag (valid during reset)
//   zero_q : out, 1 bit     - registered zero flag
//   ones_q : out, 1 bit     - registered all-ones flag
//   lzc_q  : out, CW bits   - registered leading-zero count
//   zcnt_q : out, 16 bits   - registered saturating count of zero captures
// -----------------------------------------------------------------------------
module cero
    import cero_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int CW   = cw_of(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    output logic              Y,
    output logic              zero_q,
    output logic              ones_q,
    output logic [CW-1:0]     lzc_q,
    output logic [15:0]       zcnt_q
);

    // Reject unsupported widths while elaborating.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("cero: WIDTH must lie in 2..64");
    end

    logic              zero_s;
    logic              ones_s;
    logic [CW-1:0]     lzc_s;

    logic              zero_d;
    logic              ones_d;
    logic [CW-1:0]     lzc_d;
    logic [15:0]       zcnt_d;

    // One NOR reduction feeds both the combinational flag and the register,
    // so the two can never disagree about what "zero" means.
    assign zero_s = ~|a;
    assign ones_s = &a;
    assign Y      = zero_s;

    cero_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .a     (a),
        .count (lzc_s)
    );

    // Next-state logic: capture on en, otherwise hold; the zero counter sticks
    // at its maximum instead of wrapping.
    always_comb begin
        zero_d = zero_q;
        ones_d = ones_q;
        lzc_d  = lzc_q;
        zcnt_d = zcnt_q;
        if (en) begin
            zero_d = zero_s;
            ones_d = ones_s;
            lzc_d  = lzc_s;
            if (zero_s && (zcnt_q != ZCNT_MAX)) begin
                zcnt_d = zcnt_q + 16'd1;
            end else begin
                zcnt_d = zcnt_q;
            end
        end else begin
            zero_d = zero_q;
            ones_d = ones_q;
            lzc_d  = lzc_q;
            zcnt_d = zcnt_q;
        end
    end

    // Status registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            ones_q <= 1'b0;
            lzc_q  <= {CW{1'b0}};
            zcnt_q <= 16'd0;
        end else begin
            zero_q <= zero_d;
            ones_q <= ones_d;
            lzc_q  <= lzc_d;
            zcnt_q <= zcnt_d;
        end
    end

endmodule : cero

// File: tb/tb_cero.sv
`timescale 1ns/1ps
module tb_cero;

    typedef struct {
        logic        zero;
        logic        ones;
        logic [5:0]  lzc;
        logic [15:0] zcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic        Y;
    logic        zero_q;
    logic        ones_q;
    logic [5:0]  lzc_q;
    logic [15:0] zcnt_q;

    int total;
    int bad;

    exp_t sb[$];

    // bench reference state
    logic        m_zero;
    logic        m_ones;
    logic [5:0]  m_lzc;
    logic [15:0] m_zcnt;

    cero dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .Y      (Y),
        .zero_q (zero_q),
        .ones_q (ones_q),
        .lzc_q  (lzc_q),
        .zcnt_q (zcnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_lzc(input logic [31:0] v);
        int n;
        logic [31:0] t;
        n = 0;
        t = v;
        while (n < 32 && t[31] == 1'b0) begin
            t = t << 1;
            n++;
        end
        return 6'(n);
    endfunction

    task automatic model_clear();
        m_zero = 1'b0;
        m_ones = 1'b0;
        m_lzc  = 6'd0;
        m_zcnt = 16'd0;
        sb.delete();
    endtask

    // drive one operand at the falling edge, push the expected register
    // contents, then move to just after the next rising edge
    task automatic step(input logic [31:0] val, input logic e);
        exp_t x;
        @(negedge clk);
        a  = val;
        en = e;
        if (e) begin
            m_zero = (val == 32'h0);
            m_ones = (val == 32'hFFFF_FFFF);
            m_lzc  = ref_lzc(val);
            if (val == 32'h0 && m_zcnt != 16'hFFFF) m_zcnt = m_zcnt + 16'd1;
        end
        x.zero = m_zero;
        x.ones = m_ones;
        x.lzc  = m_lzc;
        x.zcnt = m_zcnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        exp_t x;
        rst = 1'b1;
        en  = 1'b0;
        a   = 32'h0;
        #3;
        total++;
        if (zero_q !== 1'b0 || ones_q !== 1'b0 || lzc_q !== 6'd0 || zcnt_q !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs: got zero=%b ones=%b lzc=%0d zcnt=%0d want all 0",
                     zero_q, ones_q, lzc_q, zcnt_q);
        end
        total++;
        if (Y !== 1'b1) begin
            bad++;
            $display("FAIL reset_y_zero: got %b want 1", Y);
        end
        a = 32'h0000_0005;
        #1;
        total++;
        if (Y !== 1'b0) begin
            bad++;
            $display("FAIL reset_y_nonzero: got %b want 0", Y);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        // en=0 first: nothing may be captured yet
        step(32'h0, 1'b0);
        x = sb.pop_front();
        total++;
        if (zero_q !== 1'b0 || zcnt_q !== 16'd0) begin
            bad++;
            $display("FAIL first_no_capture: got zero=%b zcnt=%0d want 0/0", zero_q, zcnt_q);
        end
        step(32'h0, 1'b1);
        x = sb.pop_front();
        total++;
        if (zero_q !== 1'b1 || zcnt_q !== 16'd1 || lzc_q !== 6'd32) begin
            bad++;
            $display("FAIL first_capture: got zero=%b zcnt=%0d lzc=%0d want 1/1/32",
                     zero_q, zcnt_q, lzc_q);
        end
    endtask

    task automatic test_alternate();
        exp_t x;
        logic [31:0] v;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            @(negedge clk);
            a  = v;
            en = 1'b1;
            #1;
            total++;
            if (Y !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL alt_y[%0d]: got %b want %b", i, Y, (i % 2 == 0));
            end
            // registered outputs still show the previous operand here
            x = '{zero: m_zero, ones: m_ones, lzc: m_lzc, zcnt: m_zcnt};
            total++;
            if (zero_q !== x.zero || ones_q !== x.ones) begin
                bad++;
                $display("FAIL alt_latency[%0d]: got zero=%b ones=%b want %b/%b",
                         i, zero_q, ones_q, x.zero, x.ones);
            end
            m_zero = (v == 32'h0);
            m_ones = (v == 32'hFFFF_FFFF);
            m_lzc  = ref_lzc(v);
            if (v == 32'h0) m_zcnt = m_zcnt + 16'd1;
            @(posedge clk);
            #1;
            total++;
            if (zero_q !== m_zero || ones_q !== m_ones || lzc_q !== m_lzc) begin
                bad++;
                $display("FAIL alt_capture[%0d]: got zero=%b ones=%b lzc=%0d want %b/%b/%0d",
                         i, zero_q, ones_q, lzc_q, m_zero, m_ones, m_lzc);
            end
        end
        total++;
        if (zcnt_q !== 16'd4) begin
            bad++;
            $display("FAIL alt_zcnt: got %0d want 4", zcnt_q);
        end
    endtask

    task automatic test_lzc();
        logic [31:0] vals [4];
        logic [5:0]  lz   [4];
        exp_t x;
        logic [31:0] r;
        vals[0] = 32'h0001_0000; lz[0] = 6'd15;
        vals[1] = 32'h8000_0000; lz[1] = 6'd0;
        vals[2] = 32'h0000_0001; lz[2] = 6'd31;
        vals[3] = 32'h0000_0000; lz[3] = 6'd32;
        for (int i = 0; i < 4; i++) begin
            step(vals[i], 1'b1);
            x = sb.pop_front();
            total++;
            if (lzc_q !== lz[i]) begin
                bad++;
                $display("FAIL lzc_fixed[%0d]: a=%h got %0d want %0d", i, vals[i], lzc_q, lz[i]);
            end
            total++;
            if (Y !== (vals[i] == 32'h0) || zero_q !== x.zero || ones_q !== x.ones || zcnt_q !== x.zcnt) begin
                bad++;
                $display("FAIL lzc_flags[%0d]: got Y=%b zero=%b ones=%b zcnt=%0d want %b/%b/%b/%0d",
                         i, Y, zero_q, ones_q, zcnt_q, (vals[i] == 32'h0), x.zero, x.ones, x.zcnt);
            end
        end
        for (int i = 0; i < 20; i++) begin
            r = $urandom() >> $urandom_range(0, 31);
            step(r, 1'b1);
            x = sb.pop_front();
            total++;
            if (lzc_q !== x.lzc || zero_q !== x.zero || ones_q !== x.ones || zcnt_q !== x.zcnt) begin
                bad++;
                $display("FAIL lzc_rand[%0d]: a=%h got lzc=%0d zero=%b ones=%b zcnt=%0d want %0d/%b/%b/%0d",
                         i, r, lzc_q, zero_q, ones_q, zcnt_q, x.lzc, x.zero, x.ones, x.zcnt);
            end
        end
    endtask

    task automatic test_hold();
        exp_t x;
        logic [31:0] v;
        step(32'h0000_00F0, 1'b1);
        x = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            v = (i % 3 == 0) ? 32'h0 : ((i % 3 == 1) ? 32'hFFFF_FFFF : 32'h0000_0100);
            step(v, 1'b0);
            x = sb.pop_front();
            total++;
            if (Y !== (v == 32'h0)) begin
                bad++;
                $display("FAIL hold_y[%0d]: got %b want %b", i, Y, (v == 32'h0));
            end
            total++;
            if (zero_q !== x.zero || ones_q !== x.ones || lzc_q !== x.lzc || zcnt_q !== x.zcnt
                || lzc_q !== 6'd24) begin
                bad++;
                $display("FAIL hold_regs[%0d]: got zero=%b ones=%b lzc=%0d zcnt=%0d want %b/%b/24/%0d",
                         i, zero_q, ones_q, lzc_q, zcnt_q, x.zero, x.ones, x.zcnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(32'h0, 1'b1);
            x = sb.pop_front();
        end
        total++;
        if (zcnt_q !== 16'd7) begin
            bad++;
            $display("FAIL mid_pre_zcnt: got %0d want 7", zcnt_q);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (zero_q !== 1'b0 || ones_q !== 1'b0 || lzc_q !== 6'd0 || zcnt_q !== 16'd0) begin
            bad++;
            $display("FAIL mid_async_clear: got zero=%b ones=%b lzc=%0d zcnt=%0d want all 0",
                     zero_q, ones_q, lzc_q, zcnt_q);
        end
        total++;
        if (Y !== 1'b1) begin
            bad++;
            $display("FAIL mid_y: got %b want 1", Y);
        end
        a = 32'h0000_0003;
        #1;
        total++;
        if (Y !== 1'b0) begin
            bad++;
            $display("FAIL mid_y_nonzero: got %b want 0", Y);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_saturate();
        exp_t x;
        int errs;
        errs = 0;
        apply_reset();
        for (int i = 0; i < 65540; i++) begin
            step(32'h0, 1'b1);
            x = sb.pop_front();
            if (zcnt_q !== x.zcnt) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL sat_track: %0d cycles disagreed", errs);
        end
        total++;
        if (zcnt_q !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_value: got %h want ffff", zcnt_q);
        end
        step(32'h0, 1'b1);
        x = sb.pop_front();
        total++;
        if (zcnt_q !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_nowrap: got %h want ffff", zcnt_q);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        a     = 32'h0;
        model_clear();
        test_reset();
        test_alternate();
        test_lzc();
        test_hold();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cero
